// File: rtl/sr_reg_bank.sv
// sr_reg_bank: a bank of independent set/reset channels with a shared
// conflict policy, per-channel edge pulses and a saturating conflict counter.
module sr_reg_bank #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Conflict policy encoding used when s and r are both high on a channel.
  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_RESET  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // Next-state logic: per-channel SR update, edge detection, conflict tracking.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (en) begin
        unique case ({s[i], r[i]})
          2'b10:   q_d[i] = 1'b1;
          2'b01:   q_d[i] = 1'b0;
          2'b11: begin
            unique case (mode)
              MODE_HOLD:   q_d[i] = q_q[i];
              MODE_SET:    q_d[i] = 1'b1;
              MODE_RESET:  q_d[i] = 1'b0;
              MODE_TOGGLE: q_d[i] = ~q_q[i];
              default:     q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
    // Pulses are derived from the upcoming transition so they appear in the
    // same cycle as the new q value.
    rise_d     = q_d & ~q_q;
    fall_d     = ~q_d & q_q;
    conflict_d = en & (|(s & r));
    // Clear wins over a simultaneous increment.
    if (clr_cnt)         cnt_d = '0;
    else if (conflict_d) cnt_d = sat_inc(cnt_q);
    else                 cnt_d = cnt_q;
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q        <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign q_bar        = ~q_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed self-checking bench for sr_reg_bank (WIDTH=4, CNT_W=3).
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] s, r;
  logic       clr_cnt;
  logic [3:0] q, q_bar, rise, fall;
  logic       conflict;
  logic [2:0] conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  sr_reg_bank #(.WIDTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .s            (s),
    .r            (r),
    .clr_cnt      (clr_cnt),
    .q            (q),
    .q_bar        (q_bar),
    .rise         (rise),
    .fall         (fall),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [3:0] er,
                         input logic [3:0] ef, input logic ec, input logic [2:0] en_cnt);
    chk({tag, "_q"},     {28'd0, q},            {28'd0, eq});
    chk({tag, "_qbar"},  {28'd0, q_bar},        {28'd0, ~eq});
    chk({tag, "_rise"},  {28'd0, rise},         {28'd0, er});
    chk({tag, "_fall"},  {28'd0, fall},         {28'd0, ef});
    chk({tag, "_conf"},  {31'd0, conflict},     {31'd0, ec});
    chk({tag, "_cnt"},   {29'd0, conflict_cnt}, {29'd0, en_cnt});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'b01; s = 4'b1111; r = 4'b0000; clr_cnt = 1'b0;
    step(); step();
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Basic set on channels 0 and 2.
    rst_n = 1'b1; en = 1'b1; mode = 2'b00; s = 4'b0101; r = 4'b0000;
    step();
    chk_all("set0101", 4'b0101, 4'b0101, 4'b0000, 1'b0, 3'd0);
    s = 4'b0000; r = 4'b0000;
    step();
    chk_all("hold0101", 4'b0101, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Conflict policies: hold, set, reset.
    s = 4'b1111; r = 4'b1111; mode = 2'b00;
    step();
    chk_all("m00", 4'b0101, 4'b0000, 4'b0000, 1'b1, 3'd1);
    mode = 2'b01;
    step();
    chk_all("m01", 4'b1111, 4'b1010, 4'b0000, 1'b1, 3'd2);
    mode = 2'b10;
    step();
    chk_all("m10", 4'b0000, 4'b0000, 4'b1111, 1'b1, 3'd3);

    // Toggle on channel 0 only; counter reaches 7.
    mode = 2'b11; s = 4'b0001; r = 4'b0001;
    step(); chk_all("tog1", 4'b0001, 4'b0001, 4'b0000, 1'b1, 3'd4);
    step(); chk_all("tog2", 4'b0000, 4'b0000, 4'b0001, 1'b1, 3'd5);
    step(); chk_all("tog3", 4'b0001, 4'b0001, 4'b0000, 1'b1, 3'd6);
    step(); chk_all("tog4", 4'b0000, 4'b0000, 4'b0001, 1'b1, 3'd7);

    // Clear with no conflict; q and flags unaffected.
    clr_cnt = 1'b1; s = 4'b0000; r = 4'b0000; mode = 2'b00;
    step();
    chk_all("clr_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);
    clr_cnt = 1'b0;

    // Saturation over 10 conflict cycles in hold mode.
    s = 4'b1111; r = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("sat_cnt", {29'd0, conflict_cnt}, (i < 7) ? i + 1 : 7);
    end
    chk_all("sat_end", 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd7);

    // Clear overrides a simultaneous conflict increment.
    clr_cnt = 1'b1;
    step();
    chk_all("clr_conf", 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd0);
    clr_cnt = 1'b0;
    step();
    chk_all("conf_after_clr", 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd1);

    // Disabled: nothing moves, conflict drops, count holds.
    en = 1'b0; s = 4'b1111; r = 4'b0000; mode = 2'b01;
    step();
    chk_all("en0_set", 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1);
    s = 4'b1111; r = 4'b1111; mode = 2'b11;
    step();
    chk_all("en0_conf", 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1);

    // Channel independence: mixed per-bit commands.
    en = 1'b1; s = 4'b1010; r = 4'b0101; mode = 2'b00;
    step();
    chk_all("mix", 4'b1010, 4'b1010, 4'b0000, 1'b0, 3'd1);
    s = 4'b0000; r = 4'b0000;
    step();
    chk_all("mix_hold", 4'b1010, 4'b0000, 4'b0000, 1'b0, 3'd1);

    // Reset mid-cycle: no change until the edge, then cleared with no fall pulse.
    rst_n = 1'b0; en = 1'b1; s = 4'b0101; r = 4'b1010; clr_cnt = 1'b0;
    #2;
    chk_all("rst_pre_edge", 4'b1010, 4'b0000, 4'b0000, 1'b0, 3'd1);
    step();
    chk_all("rst_edge", 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // First edge after release evaluates inputs normally.
    rst_n = 1'b1; s = 4'b0101; r = 4'b0000;
    step();
    chk_all("post_rst", 4'b0101, 4'b0101, 4'b0000, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_reg_bank.md
SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 4, giving the number of independent SR channels (legal range 1..32).
REQ-002 The block SHALL have a parameter CNT_W, default 8, giving the width of the conflict counter (legal range 2..16).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst_n: input, 1 bit, synchronous active-low reset.
REQ-006 Port en: input, 1 bit, update enable for all channels.
REQ-007 Port mode: input, 2 bits, conflict policy applied when s=r=1 on a channel.
REQ-008 Port s: input, WIDTH bits, per-channel set.
REQ-009 Port r: input, WIDTH bits, per-channel reset.
REQ-010 Port clr_cnt: input, 1 bit, synchronous clear of conflict_cnt.
REQ-011 Port q: output, WIDTH bits, registered channel state.
REQ-012 Port q_bar: output, WIDTH bits, bitwise complement of q at all times.
REQ-013 Port rise: output, WIDTH bits, one-cycle pulse per channel on a q 0->1 transition.
REQ-014 Port fall: output, WIDTH bits, one-cycle pulse per channel on a q 1->0 transition.
REQ-015 Port conflict: output, 1 bit, registered flag: at least one channel saw s=r=1 while enabled.
REQ-016 Port conflict_cnt: output, CNT_W bits, saturating count of conflict cycles.

Function
REQ-017 All outputs SHALL be registered, except q_bar, which SHALL be combinationally derived as ~q.
REQ-018 With en=1, each channel's next q SHALL be: s=1,r=0 -> 1; s=0,r=1 -> 0; s=0,r=0 -> hold.
REQ-019 With en=1 and s=r=1, the channel's next q SHALL follow mode: 00 hold, 01 set (1), 10 reset (0), 11 toggle (~q).
REQ-020 mode SHALL be sampled every cycle; a mode change SHALL take effect on the same edge that samples it, with no pipeline delay.
REQ-021 Channels SHALL be fully independent; the inputs of one channel SHALL NOT affect any other channel's q.
REQ-022 Latency SHALL be one cycle: inputs sampled at edge N SHALL be reflected in q after edge N.
REQ-023 rise[i] SHALL be 1 for exactly the cycle following an edge at which q[i] changed 0->1; fall[i] likewise for 1->0; both SHALL otherwise be 0.
REQ-024 With en=0, q SHALL hold, and rise, fall and conflict SHALL be 0 on the next cycle regardless of s, r and mode.
REQ-025 conflict SHALL register (en AND OR-reduction of (s AND r)).
REQ-026 conflict_cnt SHALL increment by exactly 1 per cycle in which the registered conflict condition is true, regardless of how many channels conflict.
REQ-027 conflict_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 clr_cnt=1 SHALL set conflict_cnt to 0 on the next edge, overriding a simultaneous increment.
REQ-029 clr_cnt SHALL affect only conflict_cnt; q, rise, fall and conflict SHALL be unaffected.
REQ-030 Toggle mode with s=r=1 held SHALL toggle q every enabled cycle and SHALL pulse rise and fall alternately.

Reset
REQ-031 At a rising edge with rst_n=0, the block SHALL set q=0, rise=0, fall=0, conflict=0 and conflict_cnt=0, so q_bar reads all ones.
REQ-032 Reset SHALL take priority over en, s, r, mode and clr_cnt.
REQ-033 Reset asserted mid-operation SHALL produce no rise or fall pulse on the following cycle, even if q was nonzero.
REQ-034 Between clock edges, a change on rst_n SHALL NOT change any output.
REQ-035 On the first edge after rst_n deasserts, the block SHALL evaluate inputs normally.

Verification (WIDTH=4, CNT_W=3)
REQ-036 Reset, then en=1, s=0101, r=0000 for one cycle -> q=0101, q_bar=1010, rise=0101, fall=0000; next cycle, s=r=0 -> q=0101, rise=0000.
REQ-037 From q=0101, apply s=r=1111 in modes 00, 01, 10 in turn -> q=0101, then q=1111, then q=0000; conflict=1 each cycle; conflict_cnt=3.
REQ-038 From q=0000, apply mode=11, s=r=0001 for 4 cycles -> q[0] sequence 1,0,1,0; rise[0] and fall[0] alternate; other bits hold at 0.
REQ-039 Hold s=r=1111 for 10 enabled cycles -> conflict_cnt saturates at 7; then assert clr_cnt together with a conflict -> conflict_cnt=0.
REQ-040 Set en=0 with s=1111, r=0000 -> q unchanged, rise=0000, conflict=0, count unchanged.
REQ-041 Assert rst_n=0 while q=1010 -> q=0000, fall=0000, conflict_cnt=0 after the edge; the bench also checks no output change before that edge.
